// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph table and FSM state type for the seven-segment bus reader
package seg7_pkg;

    // Active-low segment patterns, bit0=a .. bit6=g, indexed by the nibble they show
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HELD
    } seg7_state_t;

endpackage

// File: rtl/seg7_glyph_lookup.sv
// rtl/seg7_glyph_lookup.sv - maps an active-low segment pattern back to its hex nibble
module seg7_glyph_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_n == SEG_GLYPH[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

    assign blank = (seg_n == SEG_BLANK);

endmodule

// File: rtl/seg7_hex_reader.sv
// rtl/seg7_hex_reader.sv - debounces a multiplexed 7-segment bus and recovers per-digit nibbles
module seg7_hex_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    bad_glyph,
    output logic                    frame_done
);

    localparam int CW = $clog2(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0] samp_sel, prev_sel;
    logic [6:0]            samp_seg, prev_seg;
    logic [CW-1:0]         cnt, cnt_nxt;
    seg7_state_t           state, state_nxt;
    logic [NUM_DIGITS-1:0] seen, seen_nxt;
    logic                  onehot, same, accept;
    logic                  hit, blank;
    logic [3:0]            nibble;

    seg7_glyph_lookup u_lookup (
        .seg_n  (samp_seg),
        .hit    (hit),
        .blank  (blank),
        .nibble (nibble)
    );

    assign onehot   = (samp_sel != '0) && ((samp_sel & (samp_sel - NUM_DIGITS'(1))) == '0);
    assign same     = (samp_sel == prev_sel) && (samp_seg == prev_seg);
    assign seen_nxt = seen | samp_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_sel <= '0;
            samp_seg <= '0;
            prev_sel <= '0;
            prev_seg <= '0;
            cnt      <= '0;
            state    <= IDLE;
        end else begin
            samp_sel <= dig_sel;
            samp_seg <= seg_n;
            prev_sel <= samp_sel;
            prev_seg <= samp_seg;
            cnt      <= cnt_nxt;
            state    <= state_nxt;
        end
    end

    // The count is of equal sample pairs, so the final pair lands on STABLE_CYCLES-2
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (onehot) state_nxt = COUNT;
            end
            COUNT: begin
                if (!onehot) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (!same) begin
                    cnt_nxt = '0;
                end else if (cnt == CW'(STABLE_CYCLES - 2)) begin
                    accept    = 1'b1;
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!same) begin
                    cnt_nxt   = '0;
                    state_nxt = onehot ? COUNT : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_out     <= '0;
            digit_valid <= '0;
            bad_glyph   <= 1'b0;
            frame_done  <= 1'b0;
            seen        <= '0;
        end else begin
            bad_glyph  <= 1'b0;
            frame_done <= 1'b0;
            if (accept) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (samp_sel[i]) begin
                        if (hit) begin
                            hex_out[4*i +: 4] <= nibble;
                            digit_valid[i]    <= 1'b1;
                        end else begin
                            digit_valid[i]    <= 1'b0;
                        end
                    end
                end
                if (!hit && !blank) bad_glyph <= 1'b1;
                // Completing digit starts the next frame with an empty mask
                if (&seen_nxt) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen       <= seen_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_hex_reader.sv
// tb/tb_seg7_hex_reader.sv - directed self-checking bench for seg7_hex_reader
module tb_seg7_hex_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_sel = 4'b0000;
    logic [15:0] hex_out;
    logic [3:0]  digit_valid;
    logic        bad_glyph;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int bad_cnt = 0;
    int frame_cnt = 0;
    int pulses;
    int pulse_pos;
    logic [6:0] fr_seg [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

    seg7_hex_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_n       (seg_n),
        .dig_sel     (dig_sel),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .bad_glyph   (bad_glyph),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bad_glyph)  bad_cnt++;
            if (frame_done) frame_cnt++;
        end
    endtask

    initial begin
        // Asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        chk("rst_hex",   32'(hex_out), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_bad",   32'(bad_glyph), 32'h0);
        chk("rst_frame", 32'(frame_done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bad_cnt = 0; frame_cnt = 0;
        tick(10);
        chk("idle_hex",    32'(hex_out), 32'h0);
        chk("idle_valid",  32'(digit_valid), 32'h0);
        chk("idle_pulses", 32'(bad_cnt + frame_cnt), 32'h0);

        // Single digit: digit 1 shows 5
        dig_sel = 4'b0010; seg_n = 7'h12;
        tick(4);
        chk("single_early_hex", 32'(hex_out), 32'h0);
        tick(1);
        chk("single_hex",   32'(hex_out), 32'h0050);
        chk("single_valid", 32'(digit_valid), 32'b0010);
        bad_cnt = 0; frame_cnt = 0;
        tick(20);
        chk("single_hold_hex",    32'(hex_out), 32'h0050);
        chk("single_hold_valid",  32'(digit_valid), 32'b0010);
        chk("single_hold_pulses", 32'(bad_cnt + frame_cnt), 32'h0);

        // Glitch: 3 cycles of '0' then '1' on digit 0
        dig_sel = 4'b0001; seg_n = 7'h40;
        tick(3);
        seg_n = 7'h79;
        tick(4);
        chk("glitch_short_hex",   32'(hex_out), 32'h0050);
        chk("glitch_short_valid", 32'(digit_valid), 32'b0010);
        tick(1);
        chk("glitch_hex",   32'(hex_out), 32'h0051);
        chk("glitch_valid", 32'(digit_valid), 32'b0011);

        // Toggling every cycle never settles
        dig_sel = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            seg_n = (k % 2 == 0) ? 7'h24 : 7'h30;
            tick(1);
        end
        chk("toggle_hex",   32'(hex_out), 32'h0051);
        chk("toggle_valid", 32'(digit_valid), 32'b0011);

        // Two full frames; pulse expected only with the digit-3 update
        for (int p = 0; p < 2; p++) begin
            pulses = 0; pulse_pos = 0;
            for (int d = 0; d < 4; d++) begin
                dig_sel = 4'(1 << d); seg_n = fr_seg[d];
                for (int c = 1; c <= 6; c++) begin
                    @(negedge clk);
                    if (frame_done) begin
                        pulses++;
                        pulse_pos = d * 10 + c;
                    end
                end
            end
            chk($sformatf("frame%0d_hex", p),    32'(hex_out), 32'h3210);
            chk($sformatf("frame%0d_valid", p),  32'(digit_valid), 32'b1111);
            chk($sformatf("frame%0d_pulses", p), 32'(pulses), 32'd1);
            chk($sformatf("frame%0d_pos", p),    32'(pulse_pos), 32'd35);
        end

        // Bad glyph on digit 2
        bad_cnt = 0; frame_cnt = 0;
        dig_sel = 4'b0100; seg_n = 7'h7E;
        tick(5);
        chk("bad_pulse", 32'(bad_glyph), 32'h1);
        chk("bad_valid", 32'(digit_valid), 32'b1011);
        chk("bad_hex",   32'(hex_out), 32'h3210);
        tick(1);
        chk("bad_width", 32'(bad_cnt), 32'd1);

        // Restore digit 2, then blank it
        seg_n = 7'h24;
        tick(6);
        chk("restore_valid", 32'(digit_valid), 32'b1111);
        bad_cnt = 0;
        seg_n = 7'h7F;
        tick(6);
        chk("blank_valid", 32'(digit_valid), 32'b1011);
        chk("blank_hex",   32'(hex_out), 32'h3210);
        chk("blank_bad",   32'(bad_cnt), 32'd0);
        chk("no_frame",    32'(frame_cnt), 32'd0);

        // Illegal selects
        bad_cnt = 0; frame_cnt = 0;
        dig_sel = 4'b0011; seg_n = 7'h00;
        tick(10);
        dig_sel = 4'b0000;
        tick(10);
        chk("illegal_hex",    32'(hex_out), 32'h3210);
        chk("illegal_valid",  32'(digit_valid), 32'b1011);
        chk("illegal_pulses", 32'(bad_cnt + frame_cnt), 32'd0);

        // Reset at count 2 of a valid pattern, pattern held throughout
        dig_sel = 4'b1000; seg_n = 7'h00;
        tick(4);
        #2 reset = 1'b1;
        #1;
        chk("midrst_hex",   32'(hex_out), 32'h0);
        chk("midrst_valid", 32'(digit_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick(4);
        chk("postrst_early_hex",   32'(hex_out), 32'h0);
        chk("postrst_early_valid", 32'(digit_valid), 32'h0);
        tick(1);
        chk("postrst_hex",   32'(hex_out), 32'h8000);
        chk("postrst_valid", 32'(digit_valid), 32'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_hex_reader.md
Name: seg7_hex_reader

Overview:
Reverse path of the hex-to-seven-segment display driver: monitors a time-multiplexed, active-low 7-segment bus (segment pattern plus one-hot digit select) and recovers the hex nibble shown on each digit. Each pattern is debounced by requiring it to be stable for a set number of cycles, then decoded and stored per digit. The block flags unrecognised glyphs and pulses once when every digit has been refreshed. It is used for display loop-back checking and for scraping values off display buses in lab top-levels.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
seg_n  input  7  segment pattern, active-low, bit0=a .. bit6=g
dig_sel  input  NUM_DIGITS  one-hot digit select, active-high
hex_out  output  4*NUM_DIGITS  decoded nibbles, digit i in bits [4i+3:4i]
digit_valid  output  NUM_DIGITS  1 = last accepted pattern for digit i was a legal glyph
bad_glyph  output  1  one-cycle pulse: accepted pattern matched no glyph
frame_done  output  1  one-cycle pulse: every digit accepted at least once since last pulse/reset

Behaviour:
- Reset (async assert, sync release): hex_out=0, digit_valid=0, bad_glyph=0, frame_done=0, seen mask=0, sample register=0, counter=0, FSM=IDLE.
- Inputs are registered once ({dig_sel, seg_n} sample). All comparisons use the sample and the previous sample.
- Glyph table (seg_n as g..a hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E. Blank=7F.
- FSM states:
  - IDLE: sample dig_sel not exactly one-hot (zero or multi-hot). Counter held at 0. Go to COUNT when the sample is one-hot.
  - COUNT: counter increments while sample == previous sample. Any change resets the counter to 0 and stays in COUNT (returns to IDLE if not one-hot). When the counter reaches STABLE_CYCLES-1, acceptance happens on that edge and the FSM goes to HELD.
  - HELD: the pattern has already been accepted. No re-acceptance while the sample is unchanged. Any change goes to COUNT with counter=0 (IDLE if not one-hot).
- Acceptance for digit i (index of the dig_sel bit):
  - legal glyph: hex_out[i] = nibble, digit_valid[i] = 1.
  - blank (7F): hex_out[i] unchanged, digit_valid[i] = 0, no bad_glyph.
  - any other pattern: hex_out[i] unchanged, digit_valid[i] = 0, bad_glyph = 1 for one cycle.
  - In all three cases seen[i] is set.
- Latency: a pattern first presented at edge t (and held) updates the outputs at edge t+STABLE_CYCLES, and is visible after that edge.
- frame_done: asserted in the same cycle the accepting update makes seen all-ones. seen clears on that same edge; an accepting digit on that edge counts toward the next frame only if it is a later acceptance. Re-accepting an already-seen digit does not change seen.
- A pattern toggling every cycle, or shorter than STABLE_CYCLES, never updates anything.
- Reset mid-count discards the partial count; nothing is updated.

Decomposition:
- Package seg7_pkg: SEG_GLYPH[16] constant array (active-low patterns above), SEG_BLANK=7'h7F, state enum {IDLE, COUNT, HELD}.
- Sub-module seg7_glyph_lookup: combinational. Input seg_n[6:0]. Outputs hit, blank, nibble[3:0].
- Top-level holds sample registers, counter, FSM, per-digit storage, seen mask, and the one-hot check.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately. Release, idle 10 cycles -> outputs remain 0, no pulses.
- Single digit: dig_sel=0010, seg_n=12 held 4 cycles -> at edge t+4 hex_out[7:4]=5, digit_valid=0010. Hold 20 more cycles -> no further change.
- Glitch: dig_sel=0001, seg_n=40 held 3 cycles, then switched to 79 -> no update after the 3 cycles. Digit 0 becomes 1 four cycles after the switch.
- Full frame: digits 0..3 given 40, 79, 24, 30 for 6 cycles each -> hex_out=16'h3210, digit_valid=1111, frame_done a single pulse coinciding with the digit-3 update. Repeat -> second pulse.
- Bad/blank: digit 2 given 7E -> bad_glyph one-cycle pulse, digit_valid[2]=0, hex_out[11:8] unchanged. Digit 2 given 7F -> digit_valid[2]=0, no bad_glyph.
- Illegal select: dig_sel=0011 or 0000 for 10 cycles with seg_n=00 -> no update. Reset asserted at count 2 of a valid pattern -> no update after release.
